// File: rtl/math_mult_arb_pkg.sv
// Shared types and helpers for the multiplier arbiter slice.
package math_mult_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      RSP  = 2'd2
   } state_t;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int unsigned id_width(input int unsigned r);
      return (r <= 1) ? 1 : unsigned'($clog2(r));
   endfunction

endpackage

// File: rtl/math_multiplier_array.sv
// Unsigned N x N array multiplier producing a full-width 2N-bit product.
module math_multiplier_array
   import math_mult_arb_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] product_c
);

   localparam int unsigned PW = 2 * N;

   // Sum of shifted partial products, one row per multiplicand bit.
   always_comb begin
      product_c = '0;
      for (int i = 0; i < N; i++) begin
         if (b[i]) begin
            product_c = product_c + (PW'(a) << i);
         end
      end
   end

endmodule

// File: rtl/math_multiplier_arbiter.sv
// Arbitrates R requesters onto one multiplier: IDLE -> MUL -> RSP.
// Define MATH_MULT_ARB_RR_EN for round-robin grant; default is fixed priority.
module math_multiplier_arbiter
   import math_mult_arb_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned R = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [R-1:0]             i_req_valid,
   output logic [R-1:0]             o_req_ready,
   input  logic [R*N-1:0]           i_req_multiplier,
   input  logic [R*N-1:0]           i_req_multiplicand,
   output logic                     o_rsp_valid,
   input  logic                     i_rsp_ready,
   output logic [2*N-1:0]           o_rsp_product,
   output logic [id_width(R)-1:0]   o_rsp_id,
   output logic                     o_busy
);

   localparam int unsigned IW = id_width(R);
   localparam int unsigned PW = 2 * N;

   state_t          state;
   logic [N-1:0]    mult_q;
   logic [N-1:0]    mcand_q;
   logic [N-1:0]    mult_sel_c;
   logic [N-1:0]    mcand_sel_c;
   logic [PW-1:0]   product_c;
   logic [IW-1:0]   grant_c;
   logic            any_valid_c;

   assign any_valid_c = |i_req_valid;

`ifdef MATH_MULT_ARB_RR_EN
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   grant_hi_c;
   logic [IW-1:0]   grant_lo_c;
   logic            hit_hi_c;

   // Lowest valid index at or above the pointer, else wrap to the lowest valid index.
   always_comb begin
      grant_hi_c = '0;
      grant_lo_c = '0;
      hit_hi_c   = 1'b0;
      for (int k = int'(R) - 1; k >= 0; k--) begin
         if (i_req_valid[k]) begin
            grant_lo_c = IW'(k);
            if (IW'(k) >= ptr) begin
               grant_hi_c = IW'(k);
               hit_hi_c   = 1'b1;
            end
         end
      end
      grant_c = hit_hi_c ? grant_hi_c : grant_lo_c;
   end
`else
   // Fixed priority: lowest valid index wins.
   always_comb begin
      grant_c = '0;
      for (int k = int'(R) - 1; k >= 0; k--) begin
         if (i_req_valid[k]) begin
            grant_c = IW'(k);
         end
      end
   end
`endif

   // Operand mux for the granted requester.
   always_comb begin
      mult_sel_c  = '0;
      mcand_sel_c = '0;
      for (int k = 0; k < int'(R); k++) begin
         if (grant_c == IW'(k)) begin
            mult_sel_c  = i_req_multiplier[k*N +: N];
            mcand_sel_c = i_req_multiplicand[k*N +: N];
         end
      end
   end

   // Ready is offered only in IDLE, outside reset, to the single granted requester.
   always_comb begin
      o_req_ready = '0;
      for (int k = 0; k < int'(R); k++) begin
         o_req_ready[k] = (state == IDLE) && !i_rst && any_valid_c && (grant_c == IW'(k));
      end
   end

   math_multiplier_array #(
      .N (N)
   ) u_mul (
      .a         (mult_q),
      .b         (mcand_q),
      .product_c (product_c)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= IDLE;
         mult_q        <= '0;
         mcand_q       <= '0;
         o_rsp_valid   <= 1'b0;
         o_rsp_product <= '0;
         o_rsp_id      <= '0;
         o_busy        <= 1'b0;
`ifdef MATH_MULT_ARB_RR_EN
         ptr           <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (any_valid_c) begin
                  mult_q   <= mult_sel_c;
                  mcand_q  <= mcand_sel_c;
                  o_rsp_id <= grant_c;
                  o_busy   <= 1'b1;
                  state    <= MUL;
`ifdef MATH_MULT_ARB_RR_EN
                  ptr      <= (grant_c == IW'(R - 1)) ? '0 : grant_c + IW'(1);
`endif
               end
            end
            MUL: begin
               o_rsp_product <= product_c;
               o_rsp_valid   <= 1'b1;
               state         <= RSP;
            end
            RSP: begin
               if (i_rsp_ready) begin
                  o_rsp_valid <= 1'b0;
                  o_busy      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               o_rsp_valid <= 1'b0;
               o_busy      <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_math_multiplier_arbiter.sv
// Self-checking bench for math_multiplier_arbiter (N=8, R=4) against a timing-level model.
// Honours MATH_MULT_ARB_RR_EN the same way the design does.
module tb_math_multiplier_arbiter;

   localparam int N  = 8;
   localparam int R  = 4;
   localparam int IW = 2;
   localparam int PW = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [R-1:0]    req_valid;
   logic [R-1:0]    req_ready;
   logic [R*N-1:0]  req_mult;
   logic [R*N-1:0]  req_mcand;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [PW-1:0]   rsp_product;
   logic [IW-1:0]   rsp_id;
   logic            busy;

   logic [N-1:0]    op_a [R];
   logic [N-1:0]    op_b [R];
   logic [R-1:0]    vld;
   bit              hold_all;

   int n_checks = 0;
   int n_fails  = 0;

   // Model: a transaction is outstanding from its accept edge until the response handshake.
   bit              m_busy = 1'b0;
   int              m_acc_e = 0;
   int              ecnt = 0;
   logic [PW-1:0]   m_prod = '0;
   int              m_id = 0;
   int              m_ptr = 0;
   bit              armed = 1'b0;
   bit              m_acc_flag = 1'b0;
   int              m_acc_id = 0;
   int              acc_q [$];

   always #5 clk = ~clk;

   assign req_valid = vld;

   always_comb begin
      req_mult  = '0;
      req_mcand = '0;
      for (int k = 0; k < R; k++) begin
         req_mult[k*N +: N]  = op_a[k];
         req_mcand[k*N +: N] = op_b[k];
      end
   end

   math_multiplier_arbiter #(
      .N (N),
      .R (R)
   ) dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_req_valid        (req_valid),
      .o_req_ready        (req_ready),
      .i_req_multiplier   (req_mult),
      .i_req_multiplicand (req_mcand),
      .o_rsp_valid        (rsp_valid),
      .i_rsp_ready        (rsp_ready),
      .o_rsp_product      (rsp_product),
      .o_rsp_id           (rsp_id),
      .o_busy             (busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // First valid requester searching upward from ptr modulo R; fixed priority keeps ptr at 0.
   function automatic int grant_of(input logic [R-1:0] v, input int ptr);
      for (int i = 0; i < R; i++) begin
         int idx;
         idx = (ptr + i) % R;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic bit rsp_due();
      return m_busy && (ecnt >= m_acc_e + 2);
   endfunction

   task automatic model_step();
      int g;
      logic [PW-1:0] pa;
      logic [PW-1:0] pb;
      m_acc_flag = 1'b0;
      if (rst) begin
         m_busy = 1'b0;
         m_ptr  = 0;
      end else if (m_busy) begin
         if (rsp_due() && rsp_ready) m_busy = 1'b0;
      end else if (req_valid != '0) begin
         g          = grant_of(req_valid, m_ptr);
         pa         = PW'(req_mult[g*N +: N]);
         pb         = PW'(req_mcand[g*N +: N]);
         m_prod     = pa * pb;
         m_id       = g;
         m_busy     = 1'b1;
         m_acc_e    = ecnt;
         m_acc_flag = 1'b1;
         m_acc_id   = g;
         acc_q.push_back(g);
`ifdef MATH_MULT_ARB_RR_EN
         m_ptr      = (g + 1) % R;
`endif
      end
      ecnt++;
      armed = 1'b1;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial forever begin
      logic [R-1:0] exp_ready;
      bit           exp_rv;
      @(negedge clk);
      if (armed) begin
         exp_ready = '0;
         if (!rst && !m_busy && req_valid != '0) exp_ready[grant_of(req_valid, m_ptr)] = 1'b1;
         exp_rv = rsp_due();
         check("cyc_req_ready", 64'(req_ready), 64'(exp_ready));
         check("cyc_rsp_valid", 64'(rsp_valid), 64'(exp_rv));
         check("cyc_busy", 64'(busy), 64'(m_busy));
         if (exp_rv) begin
            check("cyc_rsp_product", 64'(rsp_product), 64'(m_prod));
            check("cyc_rsp_id", 64'(rsp_id), 64'(m_id));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (!hold_all && m_acc_flag) vld[m_acc_id] = 1'b0;
   endtask

   task automatic drain();
      rsp_ready = 1'b1;
      tick();
      for (int i = 0; i < 200; i++) begin
         if (vld == '0 && !busy) break;
         tick();
      end
      check("drain_idle", 64'(vld != '0 || busy), 64'(0));
   endtask

   task automatic single(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [PW-1:0] prod, output logic [IW-1:0] id, output int lat);
      drain();
      op_a[k] = a;
      op_b[k] = b;
      vld[k]  = 1'b1;
      lat     = -1;
      @(negedge clk);
      for (int i = 1; i <= 20; i++) begin
         tick();
         @(negedge clk);
         if (rsp_valid) begin
            lat = i;
            break;
         end
      end
      prod = rsp_product;
      id   = rsp_id;
   endtask

   function automatic logic [N-1:0] rnd_op();
      case ($urandom_range(7))
         0:       return '0;
         1:       return '1;
         default: return N'($urandom);
      endcase
   endfunction

   initial begin
      logic [PW-1:0] prod;
      logic [IW-1:0] id;
      int            lat;
      int            exp_order [$];
      int            done;

      rst       = 1'b1;
      rsp_ready = 1'b0;
      hold_all  = 1'b0;
      for (int k = 0; k < R; k++) begin
         op_a[k] = N'(k + 1);
         op_b[k] = N'(k + 7);
      end
      vld = '1;

      // Reset with all requesters valid: nothing may be offered ready.
      repeat (3) tick();
      @(negedge clk);
      check("reset_req_ready", 64'(req_ready), 64'(0));
      check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      check("reset_product", 64'(rsp_product), 64'(0));
      check("reset_id", 64'(rsp_id), 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      tick();
      vld = '0;
      rst = 1'b0;

      // Single request 3 x 5 on requester 0.
      single(0, 8'd3, 8'd5, prod, id, lat);
      check("single_product", 64'(prod), 64'd15);
      check("single_id", 64'(id), 64'd0);
      check("single_latency", 64'(lat), 64'd2);
      tick();
      @(negedge clk);
      check("single_back_idle", 64'(busy), 64'd0);

      // All four valid and held from a fresh reset.
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      acc_q.delete();
      hold_all  = 1'b1;
      rsp_ready = 1'b1;
      vld       = '1;
      repeat (16) tick();
      hold_all = 1'b0;
      vld      = '0;
`ifdef MATH_MULT_ARB_RR_EN
      exp_order = '{0, 1, 2, 3, 0};
`else
      exp_order = '{0, 0, 0};
`endif
      check("order_count_enough", 64'(acc_q.size() >= exp_order.size()), 64'd1);
      for (int i = 0; i < exp_order.size() && i < acc_q.size(); i++) begin
         check($sformatf("order_%0d", i), 64'(acc_q[i]), 64'(exp_order[i]));
      end

      // Backpressure: response held while other requesters wait.
      drain();
      rsp_ready = 1'b0;
      op_a[2] = 8'd9;
      op_b[2] = 8'd7;
      vld[2]  = 1'b1;
      tick();
      vld[1] = 1'b1;
      vld[3] = 1'b1;
      done = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            done = 1;
            break;
         end
         tick();
      end
      check("bp_rsp_arrived", 64'(done), 64'd1);
      for (int i = 0; i < 5; i++) begin
         check("bp_product", 64'(rsp_product), 64'd63);
         check("bp_id", 64'(rsp_id), 64'd2);
         check("bp_req_ready", 64'(req_ready), 64'd0);
         check("bp_busy", 64'(busy), 64'd1);
         tick();
         @(negedge clk);
      end
      drain();

      // Extreme operands.
      single(1, 8'd255, 8'd255, prod, id, lat);
      check("max_product", 64'(prod), 64'hFE01);
      check("max_id", 64'(id), 64'd1);
      single(3, 8'd0, 8'd200, prod, id, lat);
      check("zero_product", 64'(prod), 64'h0000);
      check("zero_id", 64'(id), 64'd3);

      // After a grant to 3, requesters 0 and 3 compete.
      single(3, 8'd11, 8'd12, prod, id, lat);
      check("wrap_pre_product", 64'(prod), 64'd132);
      drain();
      vld[0] = 1'b1;
      vld[3] = 1'b1;
      @(negedge clk);
      check("wrap_grant", 64'(req_ready), 64'b0001);
      drain();

      // Reset during MUL discards the operation.
      drain();
      op_a[2] = 8'd13;
      op_b[2] = 8'd17;
      vld[2]  = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("mid_reset_no_rsp", 64'(rsp_valid), 64'd0);
         check("mid_reset_busy", 64'(busy), 64'd0);
         tick();
      end
      vld[1] = 1'b1;
      vld[2] = 1'b1;
      @(negedge clk);
      check("post_reset_grant", 64'(req_ready), 64'b0010);
      drain();

      // Randomized traffic with backpressure and occasional resets.
      for (int n = 0; n < 600; n++) begin
         tick();
         rsp_ready = ($urandom_range(3) != 0);
         rst       = ($urandom_range(99) == 0);
         for (int k = 0; k < R; k++) begin
            if (!vld[k] && $urandom_range(2) == 0) begin
               op_a[k] = rnd_op();
               op_b[k] = rnd_op();
               vld[k]  = 1'b1;
            end
         end
      end
      tick();
      rst = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/math_multiplier_arbiter.md
MATH_MULTIPLIER_ARBITER -- requirements
Module: math_multiplier_arbiter

Interface
REQ-001 SHALL have parameter N, default 8: operand width in bits; legal range N >= 4.
REQ-002 SHALL have parameter R, default 4: number of requesters; legal range R >= 1.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 i_clk  input  1  clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_req_valid  input  R  per-requester request valid.
REQ-007 o_req_ready  output  R  per-requester accept, one-hot or zero.
REQ-008 i_req_multiplier  input  R*N  requester k operand at bits [k*N +: N].
REQ-009 i_req_multiplicand  input  R*N  requester k operand at bits [k*N +: N].
REQ-010 o_rsp_valid  output  1  response valid.
REQ-011 i_rsp_ready  input  1  response consumer ready.
REQ-012 o_rsp_product  output  2N  unsigned product.
REQ-013 o_rsp_id  output  max(1,$clog2(R))  index of the originating requester.
REQ-014 o_busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, RSP.
REQ-016 IDLE: if any i_req_valid bit is high, SHALL select a grant index g and assert o_req_ready[g] combinationally; all other ready bits SHALL be 0.
REQ-017 Handshake: on i_req_valid[g] & o_req_ready[g], SHALL register requester g's operands and g, then go to MUL.
REQ-018 IDLE with no valid request: SHALL remain in IDLE with o_req_ready = 0.
REQ-019 MUL: SHALL last exactly one cycle, register the 2N-bit product of the registered operands into the response register, then go to RSP.
REQ-020 RSP: SHALL hold o_rsp_valid = 1, with o_rsp_product and o_rsp_id stable, until i_rsp_ready = 1; that handshake SHALL return the FSM to IDLE.
REQ-021 Latency: o_rsp_valid SHALL rise 2 cycles after the accept edge.
REQ-022 Throughput: at most one accept per 3 cycles with i_rsp_ready held high.
REQ-023 o_req_ready SHALL be all-zero in MUL and RSP, so no request is accepted while busy.
REQ-024 Product SHALL be unsigned, full width, with no truncation: 2^N-1 squared fits in 2N bits.
REQ-025 Requesters SHALL hold valid and operands until accepted; the arbiter SHALL sample operands only on the accept edge.
REQ-026 R = 1: grant SHALL always be index 0.
REQ-027 o_rsp_valid SHALL be 0 in IDLE and MUL.

Reset
REQ-028 While i_rst = 1, at the next rising edge the block SHALL set: state IDLE, o_rsp_valid 0, o_rsp_product 0, o_rsp_id 0, o_busy 0, round-robin pointer 0.
REQ-029 While i_rst = 1, o_req_ready SHALL be 0.
REQ-030 Reset asserted in MUL or RSP SHALL discard the in-flight operation with no response emitted.

Configuration
REQ-031 Macro MATH_MULT_ARB_RR_EN defined: grant SHALL be round-robin.
- Search starts at the pointer and proceeds upward, wrapping modulo R (R need not be a power of 2).
- After each accept, pointer = (g+1) mod R.
REQ-032 Macro MATH_MULT_ARB_RR_EN undefined: grant SHALL be fixed priority (lowest valid index wins) and no pointer register SHALL exist.

Structure
REQ-033 Package math_mult_arb_pkg SHALL hold the FSM state enum typedef and the ID-width helper function.
REQ-034 SHALL instantiate one math_multiplier_array sub-module (parameter N), fed from the registered operands.

Verification (N=8, R=4)
REQ-035 Single request: req0 with operands 3,5 accepted at cycle T, i_rsp_ready=1 -> o_rsp_valid at T+2 with product 15, id 0, then return to IDLE.
REQ-036 All four requesters valid and held, RR_EN defined -> accept order 0,1,2,3,0; RR_EN undefined -> 0,0,0.
REQ-037 Backpressure: i_rsp_ready held low 5 cycles in RSP -> product and id stable, o_req_ready = 0 throughout, o_busy = 1.
REQ-038 Extreme operands: 255 x 255 -> 0xFE01; 0 x 200 -> 0x0000.
REQ-039 Wrap: with RR_EN, after a grant to 3, requests 0 and 3 valid -> grant 0.
REQ-040 Reset mid-MUL: i_rst for 1 cycle -> no o_rsp_valid; afterwards state IDLE and pointer 0, so the next simultaneous 1/2 request grants 1.
